// File: rtl/mdu_pkg.sv
// Shared definitions for the PCPI M-extension sequencer.
//   - RISC-V OP opcode and MULDIV funct7 used for instruction matching
//   - funct3 operation encoding (mdu_op_e) and sequencer states (mdu_state_e)
//   - fast-path result constants for divide-by-zero and signed overflow
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMulRun,
    StDivRun,
    StResp,
    StDrain
  } mdu_state_e;

endpackage

// File: rtl/mdu_decode.sv
// Combinational decoder for M-extension instructions.
// Ports:
//   insn          instruction word
//   rs1, rs2      operands (used only for the divide fast-path checks)
//   match         insn is an OP-opcode MULDIV instruction
//   is_div        DIV/DIVU/REM/REMU
//   is_unsigned   DIVU/REMU (funct3[0]); meaningful for divides only
//   want_rem      remainder requested (funct3[1]); meaningful for divides only
//   want_high     multiply returns the upper product word
//   mul_a_signed  rs1 is signed for the multiplier (MULH, MULHSU)
//   mul_b_signed  rs2 is signed for the multiplier (MULH)
//   div_by_zero   divide with rs2 == 0
//   signed_ovf    signed divide of INT_MIN by -1
module mdu_decode
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [31:0]      insn,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             match,
  output logic             is_div,
  output logic             is_unsigned,
  output logic             want_rem,
  output logic             want_high,
  output logic             mul_a_signed,
  output logic             mul_b_signed,
  output logic             div_by_zero,
  output logic             signed_ovf
);

  mdu_op_e op;
  assign op = mdu_op_e'(insn[14:12]);

  assign match        = (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  assign is_div       = insn[14];
  assign is_unsigned  = insn[12];
  assign want_rem     = insn[13];
  assign want_high    = (op != OpMul);
  assign mul_a_signed = (op == OpMulh) || (op == OpMulhsu);
  assign mul_b_signed = (op == OpMulh);
  assign div_by_zero  = is_div && (rs2 == '0);
  assign signed_ovf   = is_div && !is_unsigned && (rs1 == INT_MIN) && (rs2 == ALL_ONES);

  // Register specifiers are handled by the core, not here.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{insn[24:15], insn[11:7]};

endmodule

// File: rtl/mdu_pcpi_ctrl.sv
// PCPI sequencer for the M extension: accepts MUL*/DIV*/REM* from the core,
// drives an iterative divider (level start held until finished) and a
// multiplier (one-cycle start pulse), short-circuits divide-by-zero and
// signed overflow, and returns the result with a one-cycle ready/wr pulse.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2         request from the core
//   pcpi_wr/rd/wait/ready           response to the core (all registered)
//   div_start/unsigned/a/b          divider request (registered)
//   div_z/r/finished                divider result, finished is a level
//   mul_start/a_signed/b_signed/a/b multiplier request (registered)
//   mul_p/done                      multiplier product, done is a pulse
module mdu_pcpi_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pcpi_valid,
  input  logic [31:0]        pcpi_insn,
  input  logic [WIDTH-1:0]   pcpi_rs1,
  input  logic [WIDTH-1:0]   pcpi_rs2,
  output logic               pcpi_wr,
  output logic [WIDTH-1:0]   pcpi_rd,
  output logic               pcpi_wait,
  output logic               pcpi_ready,
  output logic               div_start,
  output logic               div_unsigned,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic [WIDTH-1:0]   div_z,
  input  logic [WIDTH-1:0]   div_r,
  input  logic               div_finished,
  output logic               mul_start,
  output logic               mul_a_signed,
  output logic               mul_b_signed,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               mul_done
);

  logic dec_match, dec_is_div, dec_is_unsigned, dec_want_rem, dec_want_high;
  logic dec_mul_a_signed, dec_mul_b_signed, dec_div_by_zero, dec_signed_ovf;

  mdu_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .insn         (pcpi_insn),
    .rs1          (pcpi_rs1),
    .rs2          (pcpi_rs2),
    .match        (dec_match),
    .is_div       (dec_is_div),
    .is_unsigned  (dec_is_unsigned),
    .want_rem     (dec_want_rem),
    .want_high    (dec_want_high),
    .mul_a_signed (dec_mul_a_signed),
    .mul_b_signed (dec_mul_b_signed),
    .div_by_zero  (dec_div_by_zero),
    .signed_ovf   (dec_signed_ovf)
  );

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d, rd_q, rd_d;
  logic             want_rem_q, want_rem_d, want_high_q, want_high_d;
  logic             div_start_q, div_start_d, div_unsigned_q, div_unsigned_d;
  logic             div_busy_q, div_busy_d;
  logic             mul_start_q, mul_start_d;
  logic             mul_a_signed_q, mul_a_signed_d, mul_b_signed_q, mul_b_signed_d;
  logic             wait_q, wait_d, ready_q, ready_d;
  // Remembers that pcpi_valid has dropped since entering StDrain, so a new
  // request raised right after an abort is not mistaken for the old one.
  logic             valid_low_q, valid_low_d;

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    rd_d           = rd_q;
    want_rem_d     = want_rem_q;
    want_high_d    = want_high_q;
    div_start_d    = div_start_q;
    div_unsigned_d = div_unsigned_q;
    div_busy_d     = div_busy_q;
    mul_start_d    = 1'b0;
    mul_a_signed_d = mul_a_signed_q;
    mul_b_signed_d = mul_b_signed_q;
    ready_d        = 1'b0;
    valid_low_d    = valid_low_q;

    // The divider always runs to completion, even after an abort.
    if (div_finished) div_busy_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pcpi_valid && dec_match && !div_busy_q && !div_finished) begin
          op_a_d      = pcpi_rs1;
          op_b_d      = pcpi_rs2;
          want_rem_d  = dec_want_rem;
          want_high_d = dec_want_high;
          if (!dec_is_div) begin
            mul_start_d    = 1'b1;
            mul_a_signed_d = dec_mul_a_signed;
            mul_b_signed_d = dec_mul_b_signed;
            state_d        = StMulRun;
          end else if (dec_div_by_zero) begin
            result_d = dec_want_rem ? pcpi_rs1 : ALL_ONES;
            state_d  = StResp;
          end else if (dec_signed_ovf) begin
            result_d = dec_want_rem ? '0 : INT_MIN;
            state_d  = StResp;
          end else begin
            div_start_d    = 1'b1;
            div_unsigned_d = dec_is_unsigned;
            div_busy_d     = 1'b1;
            state_d        = StDivRun;
          end
        end
      end
      StMulRun: begin
        if (!pcpi_valid) begin
          valid_low_d = 1'b1;
          state_d     = StDrain;
        end else if (mul_done) begin
          result_d = want_high_q ? mul_p[2*WIDTH-1:WIDTH] : mul_p[WIDTH-1:0];
          state_d  = StResp;
        end
      end
      StDivRun: begin
        if (!pcpi_valid) begin
          div_start_d = 1'b0;
          valid_low_d = 1'b1;
          state_d     = StDrain;
        end else if (div_finished) begin
          result_d    = want_rem_q ? div_r : div_z;
          div_start_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        ready_d = 1'b1;
        rd_d    = result_q;
        state_d = StDrain;
      end
      StDrain: begin
        if (!pcpi_valid) valid_low_d = 1'b1;
        if ((valid_low_q || !pcpi_valid) && !div_finished && !div_busy_q) begin
          valid_low_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    wait_d = (state_d == StMulRun) || (state_d == StDivRun) || (state_d == StResp);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      op_a_q         <= '0;
      op_b_q         <= '0;
      result_q       <= '0;
      rd_q           <= '0;
      want_rem_q     <= 1'b0;
      want_high_q    <= 1'b0;
      div_start_q    <= 1'b0;
      div_unsigned_q <= 1'b0;
      div_busy_q     <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_a_signed_q <= 1'b0;
      mul_b_signed_q <= 1'b0;
      wait_q         <= 1'b0;
      ready_q        <= 1'b0;
      valid_low_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      result_q       <= result_d;
      rd_q           <= rd_d;
      want_rem_q     <= want_rem_d;
      want_high_q    <= want_high_d;
      div_start_q    <= div_start_d;
      div_unsigned_q <= div_unsigned_d;
      div_busy_q     <= div_busy_d;
      mul_start_q    <= mul_start_d;
      mul_a_signed_q <= mul_a_signed_d;
      mul_b_signed_q <= mul_b_signed_d;
      wait_q         <= wait_d;
      ready_q        <= ready_d;
      valid_low_q    <= valid_low_d;
    end
  end

  assign pcpi_wr      = ready_q;
  assign pcpi_ready   = ready_q;
  assign pcpi_wait    = wait_q;
  assign pcpi_rd      = rd_q;
  assign div_start    = div_start_q;
  assign div_unsigned = div_unsigned_q;
  assign div_a        = op_a_q;
  assign div_b        = op_b_q;
  assign mul_start    = mul_start_q;
  assign mul_a_signed = mul_a_signed_q;
  assign mul_b_signed = mul_b_signed_q;
  assign mul_a        = op_a_q;
  assign mul_b        = op_b_q;

endmodule
